// File: rtl/modulo_ingresar_operando.sv
`default_nettype none
// ============================================================================
// Module      : modulo_ingresar_operando
// Description : Keypad operand-entry controller for a BCD calculator.
//               Builds a multi-digit BCD number from keypad strokes,
//               latches the first operand on an operator key and the second
//               operand on the equal key, then raises a completion pulse.
//
//               Key codes: 0-9 digit, A..D operator (+,-,*,/), E equal,
//               F clear.
//
//               Optional feature (macro BACKSPACE_EN): the 'borrar' input
//               deletes the most recently entered digit. Without the macro,
//               the port stays on the interface but drives no logic.
//
// Ports       :
//   clk           in   1            system clock, rising edge
//   reset         in   1            asynchronous reset, active low
//   tecla_valida  in   1            key held strobe (debounced, synchronous)
//   tecla_cod     in   4            key code
//   borrar        in   1            delete-last-digit key (BACKSPACE_EN only)
//   display       out  4*N_DIGITS   number being entered, LSD in [3:0]
//   operando_a    out  4*N_DIGITS   latched first operand
//   operando_b    out  4*N_DIGITS   latched second operand
//   operador      out  2            latched operator (code minus 4'hA)
//   contador      out  clog2(N+1)   digits currently in display
//   listo         out  1            one-cycle pulse: expression complete
//   desborde      out  1            one-cycle pulse: digit rejected, full
//
// Parameters  :
//   N_DIGITS      BCD digits per operand, 1..8 (default 4)
//
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_ingresar_operando #(
    parameter int N_DIGITS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               tecla_valida,
    input  logic [3:0]                         tecla_cod,
    input  logic                               borrar,
    output logic [4*N_DIGITS-1:0]              display,
    output logic [4*N_DIGITS-1:0]              operando_a,
    output logic [4*N_DIGITS-1:0]              operando_b,
    output logic [1:0]                         operador,
    output logic [$clog2(N_DIGITS+1)-1:0]      contador,
    output logic                               listo,
    output logic                               desborde
);

    localparam int C_ANCHO     = 4 * N_DIGITS;
    localparam int C_ANCHO_CNT = $clog2(N_DIGITS + 1);

    localparam logic [C_ANCHO_CNT-1:0] C_CNT_MAX  = C_ANCHO_CNT'(N_DIGITS);
    localparam logic [C_ANCHO_CNT-1:0] C_CNT_UNO  = C_ANCHO_CNT'(1);
    localparam logic [3:0]             C_COD_A    = 4'hA;
    localparam logic [3:0]             C_COD_D    = 4'hD;
    localparam logic [3:0]             C_COD_IGU  = 4'hE;
    localparam logic [3:0]             C_COD_CLR  = 4'hF;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ESPERAR_A = 3'd0,
        INGRESO_A = 3'd1,
        ESPERAR_B = 3'd2,
        INGRESO_B = 3'd3,
        LISTO     = 3'd4
    } estado_t;

    estado_t                  r_estado;
    estado_t                  w_estado_sig;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [C_ANCHO-1:0]       r_display,    w_display_sig;
    logic [C_ANCHO-1:0]       r_operando_a, w_operando_a_sig;
    logic [C_ANCHO-1:0]       r_operando_b, w_operando_b_sig;
    logic [1:0]               r_operador,   w_operador_sig;
    logic [C_ANCHO_CNT-1:0]   r_contador,   w_contador_sig;
    logic                     r_listo,      w_listo_sig;
    logic                     r_desborde,   w_desborde_sig;

    // Edge detection on the key strobe
    logic                     r_tecla_prev;
    // Cleared by reset; set once the key has been observed released. Keeps a
    // key that was held through reset release from counting as a new press.
    logic                     r_armado;
    logic                     w_evento;

    // Key decode
    logic                     w_es_digito;
    logic                     w_es_operador;
    logic                     w_es_igual;
    logic                     w_es_clear;
    logic [3:0]               w_op_completo;
    logic [C_ANCHO-1:0]       w_digito_ext;
    logic [C_ANCHO-1:0]       w_display_izq;

    assign w_evento      = tecla_valida & ~r_tecla_prev & r_armado;

    assign w_es_digito   = (tecla_cod <= 4'd9);
    assign w_es_operador = (tecla_cod >= C_COD_A) && (tecla_cod <= C_COD_D);
    assign w_es_igual    = (tecla_cod == C_COD_IGU);
    assign w_es_clear    = (tecla_cod == C_COD_CLR);
    assign w_op_completo = tecla_cod - C_COD_A;

    // Shift-in form also works for N_DIGITS = 1, where the shift yields zero.
    assign w_digito_ext  = C_ANCHO'(tecla_cod);
    assign w_display_izq = (r_display << 4) | w_digito_ext;

`ifdef BACKSPACE_EN
    logic                     r_borrar_prev;
    logic                     w_evento_borrar;

    assign w_evento_borrar = borrar & ~r_borrar_prev;
`else
    // The delete key has no function in this build.
    logic                     w_unused_borrar;

    assign w_unused_borrar = borrar;
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado      <= ESPERAR_A;
            r_display     <= '0;
            r_operando_a  <= '0;
            r_operando_b  <= '0;
            r_operador    <= '0;
            r_contador    <= '0;
            r_listo       <= 1'b0;
            r_desborde    <= 1'b0;
            r_tecla_prev  <= 1'b0;
            r_armado      <= 1'b0;
`ifdef BACKSPACE_EN
            r_borrar_prev <= 1'b0;
`endif
        end else begin
            r_estado      <= w_estado_sig;
            r_display     <= w_display_sig;
            r_operando_a  <= w_operando_a_sig;
            r_operando_b  <= w_operando_b_sig;
            r_operador    <= w_operador_sig;
            r_contador    <= w_contador_sig;
            r_listo       <= w_listo_sig;
            r_desborde    <= w_desborde_sig;
            r_tecla_prev  <= tecla_valida;
            r_armado      <= r_armado | ~tecla_valida;
`ifdef BACKSPACE_EN
            r_borrar_prev <= borrar;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath decisions
    // ------------------------------------------------------------------------
    always_comb begin
        w_estado_sig     = r_estado;
        w_display_sig    = r_display;
        w_operando_a_sig = r_operando_a;
        w_operando_b_sig = r_operando_b;
        w_operador_sig   = r_operador;
        w_contador_sig   = r_contador;
        w_listo_sig      = 1'b0;
        w_desborde_sig   = 1'b0;

        if (w_evento) begin
            if (w_es_clear) begin
                w_estado_sig     = ESPERAR_A;
                w_display_sig    = '0;
                w_operando_a_sig = '0;
                w_operando_b_sig = '0;
                w_operador_sig   = '0;
                w_contador_sig   = '0;
            end else if (w_es_digito) begin
                if (r_estado == LISTO) begin
                    // A digit after a finished expression starts a new one.
                    w_estado_sig     = INGRESO_A;
                    w_operando_a_sig = '0;
                    w_operando_b_sig = '0;
                    w_operador_sig   = '0;
                    w_display_sig    = w_digito_ext;
                    w_contador_sig   = C_CNT_UNO;
                end else if (r_contador < C_CNT_MAX) begin
                    w_display_sig  = w_display_izq;
                    w_contador_sig = r_contador + C_CNT_UNO;
                    if (r_estado == ESPERAR_A) begin
                        w_estado_sig = INGRESO_A;
                    end else if (r_estado == ESPERAR_B) begin
                        w_estado_sig = INGRESO_B;
                    end
                end else begin
                    w_desborde_sig = 1'b1;
                end
            end else if (w_es_operador) begin
                case (r_estado)
                    INGRESO_A: begin
                        w_operando_a_sig = r_display;
                        w_operador_sig   = w_op_completo[1:0];
                        w_display_sig    = '0;
                        w_contador_sig   = '0;
                        w_estado_sig     = ESPERAR_B;
                    end
                    ESPERAR_B: begin
                        // Operator changed before any B digit was typed.
                        w_operador_sig   = w_op_completo[1:0];
                    end
                    default: begin
                    end
                endcase
            end else if (w_es_igual) begin
                if (r_estado == INGRESO_B) begin
                    w_operando_b_sig = r_display;
                    w_listo_sig      = 1'b1;
                    w_estado_sig     = LISTO;
                end
            end
        end
`ifdef BACKSPACE_EN
        // Only reached when no key event is present this cycle, so a key
        // event always takes precedence over a coincident delete.
        else if (w_evento_borrar && (r_contador != '0) &&
                 ((r_estado == INGRESO_A) || (r_estado == INGRESO_B))) begin
            w_display_sig  = r_display >> 4;
            w_contador_sig = r_contador - C_CNT_UNO;
            if (r_contador == C_CNT_UNO) begin
                w_estado_sig = (r_estado == INGRESO_A) ? ESPERAR_A : ESPERAR_B;
            end
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign display    = r_display;
    assign operando_a = r_operando_a;
    assign operando_b = r_operando_b;
    assign operador   = r_operador;
    assign contador   = r_contador;
    assign listo      = r_listo;
    assign desborde   = r_desborde;

endmodule
`default_nettype wire

// File: tb/tb_modulo_ingresar_operando.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulo_ingresar_operando
// Description : Self-checking bench for modulo_ingresar_operando. A model
//               holding the typed digits in a queue predicts every output
//               after each clock edge. Honours BACKSPACE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_ingresar_operando;

    localparam int N  = 4;
    localparam int W  = 4 * N;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          reset;
    logic          tecla_valida;
    logic [3:0]    tecla_cod;
    logic          borrar;
    logic [W-1:0]  display;
    logic [W-1:0]  operando_a;
    logic [W-1:0]  operando_b;
    logic [1:0]    operador;
    logic [CW-1:0] contador;
    logic          listo;
    logic          desborde;

    modulo_ingresar_operando #(.N_DIGITS(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .tecla_valida (tecla_valida),
        .tecla_cod    (tecla_cod),
        .borrar       (borrar),
        .display      (display),
        .operando_a   (operando_a),
        .operando_b   (operando_b),
        .operador     (operador),
        .contador     (contador),
        .listo        (listo),
        .desborde     (desborde)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: entered digits (MSD first) and the expression stage
    // (0 = typing A, 1 = typing B, 2 = expression complete).
    int           q[$];
    int           etapa;
    logic [W-1:0] m_a, m_b;
    logic [1:0]   m_op;
    bit           m_listo, m_desb;
    bit           prev_v, bloqueado;
`ifdef BACKSPACE_EN
    bit           prev_b;
`endif

    function automatic logic [W-1:0] empaquetar();
        logic [W-1:0] r = '0;
        foreach (q[i]) r = (r << 4) | W'(q[i]);
        return r;
    endfunction

    task automatic modelo_reset();
        q = {};
        etapa = 0;
        m_a = '0; m_b = '0; m_op = '0;
        m_listo = 0; m_desb = 0;
        prev_v = 0;
        bloqueado = 1;
`ifdef BACKSPACE_EN
        prev_b = 0;
`endif
    endtask

    task automatic modelo_flanco(input bit v, input logic [3:0] c, input bit b);
        bit ev;
        ev = v && !prev_v && !bloqueado;
        if (!v) bloqueado = 0;
        prev_v  = v;
        m_listo = 0;
        m_desb  = 0;
        if (ev) begin
            if (c == 4'hF) begin
                q = {}; etapa = 0; m_a = '0; m_b = '0; m_op = '0;
            end else if (c <= 4'd9) begin
                if (etapa == 2) begin
                    m_a = '0; m_b = '0; m_op = '0;
                    q = {int'(c)};
                    etapa = 0;
                end else if (q.size() < N) begin
                    q.push_back(int'(c));
                end else begin
                    m_desb = 1;
                end
            end else if (c <= 4'hD) begin
                if (etapa == 0 && q.size() > 0) begin
                    m_a = empaquetar(); m_op = 2'(c - 4'hA); q = {}; etapa = 1;
                end else if (etapa == 1 && q.size() == 0) begin
                    m_op = 2'(c - 4'hA);
                end
            end else if (etapa == 1 && q.size() > 0) begin
                m_b = empaquetar(); m_listo = 1; etapa = 2;
            end
        end
`ifdef BACKSPACE_EN
        if (b && !prev_b && !ev && etapa != 2 && q.size() > 0) void'(q.pop_back());
        prev_b = b;
`else
        if (b) begin end
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_todo(input string tag);
        chk({tag, "/display"},    32'(display),    32'(empaquetar()));
        chk({tag, "/operando_a"}, 32'(operando_a), 32'(m_a));
        chk({tag, "/operando_b"}, 32'(operando_b), 32'(m_b));
        chk({tag, "/operador"},   32'(operador),   32'(m_op));
        chk({tag, "/contador"},   32'(contador),   32'(q.size()));
        chk({tag, "/listo"},      32'(listo),      32'(m_listo));
        chk({tag, "/desborde"},   32'(desborde),   32'(m_desb));
        chk({tag, "/exclusivo"},  32'(listo & desborde), 32'(0));
    endtask

    task automatic tick(input bit v, input logic [3:0] c, input bit b);
        @(negedge clk);
        tecla_valida = v; tecla_cod = c; borrar = b;
        @(posedge clk);
        modelo_flanco(v, c, b);
        #1;
        chk_todo("tick");
    endtask

    task automatic pulsar(input logic [3:0] c, input int hold);
        for (int i = 0; i < hold; i++) tick(1'b1, c, 1'b0);
        tick(1'b0, c, 1'b0);
    endtask

    initial begin
        tecla_valida = 0; tecla_cod = 0; borrar = 0;
        reset = 0;
        modelo_reset();
        #12;
        chk_todo("reset");
        @(negedge clk);
        reset = 1;
        tick(0, 0, 0);

        // Three keys each held three cycles
        pulsar(4'h1, 3); pulsar(4'h2, 3); pulsar(4'h3, 3);
        chk("req030_display",  32'(display),  32'h0123);
        chk("req030_contador", 32'(contador), 32'd3);

        // Overflow on the fifth digit
        pulsar(4'hF, 1);
        pulsar(4'h4, 1); pulsar(4'h5, 1); pulsar(4'h6, 1); pulsar(4'h7, 1);
        tick(1, 4'h8, 0);
        chk("req031_desborde", 32'(desborde), 32'd1);
        tick(0, 4'h8, 0);
        chk("req031_desborde_fin", 32'(desborde), 32'd0);
        chk("req031_display", 32'(display), 32'h4567);

        // Complete expression 12 * 3 = (A then C replaces operator)
        pulsar(4'hF, 1);
        pulsar(4'h1, 1); pulsar(4'h2, 2); pulsar(4'hA, 1); pulsar(4'hC, 1);
        pulsar(4'h3, 1);
        tick(1, 4'hE, 0);
        chk("req032_listo",      32'(listo),      32'd1);
        chk("req032_operando_a", 32'(operando_a), 32'h0012);
        chk("req032_operador",   32'(operador),   32'd2);
        chk("req032_operando_b", 32'(operando_b), 32'h0003);
        tick(1, 4'hE, 0);
        chk("req032_listo_fin",  32'(listo),      32'd0);
        tick(0, 4'hE, 0);

        // A digit after completion starts a new expression
        pulsar(4'h9, 1);
        chk("req033_display",    32'(display),    32'h0009);
        chk("req033_operando_a", 32'(operando_a), 32'h0);

        // Delete key
        pulsar(4'hF, 1);
        pulsar(4'h5, 1); pulsar(4'h6, 1);
        tick(0, 0, 1); tick(0, 0, 0);
`ifdef BACKSPACE_EN
        chk("req034_display",  32'(display),  32'h0005);
        chk("req034_contador", 32'(contador), 32'd1);
`else
        chk("req034_display",  32'(display),  32'h0056);
        chk("req034_contador", 32'(contador), 32'd2);
`endif

        // Asynchronous reset mid-entry with a key held
        tick(1, 4'h7, 0);
        #2;
        reset = 0;
        #1;
        modelo_reset();
        chk_todo("req035_async");
        @(posedge clk); #1;
        chk_todo("req035_hold");
        @(negedge clk);
        reset = 1;
        tick(1, 4'h7, 0); tick(1, 4'h7, 0); tick(1, 4'h7, 0);
        chk("req035_sin_evento", 32'(contador), 32'd0);
        tick(0, 4'h7, 0);
        pulsar(4'h7, 1);
        chk("req035_repulsado", 32'(display), 32'h0007);

        // Randomised key sequences
        for (int k = 0; k < 250; k++) begin
            int r;
            logic [3:0] c;
            int hold;
            r    = $urandom_range(0, 19);
            hold = $urandom_range(1, 3);
            if (r < 11)      c = 4'($urandom_range(0, 9));
            else if (r < 15) c = 4'($urandom_range(10, 13));
            else if (r < 18) c = 4'hE;
            else if (r < 19) c = 4'hF;
            else             c = 4'($urandom_range(0, 15));
            for (int i = 0; i < hold; i++)
                tick(1'b1, c, ($urandom_range(0, 3) == 0));
            for (int i = 0; i < int'($urandom_range(1, 2)); i++)
                tick(1'b0, c, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modulo_ingresar_operando.md
MODULO_INGRESAR_OPERANDO -- requirements
Module: modulo_ingresar_operando

Interface
REQ-001 Parameter N_DIGITS, default 4, range 1..8: BCD digits per operand.
REQ-002 clk  in  1  system clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 tecla_valida  in  1  keypad strobe, level, high while key held (already debounced and synchronous).
REQ-005 tecla_cod  in  4  key code: 0-9 digit, A/B/C/D operator (+,-,*,/), E equal, F clear.
REQ-006 borrar  in  1  delete-last-digit key, level; ignored unless BACKSPACE_EN defined.
REQ-007 display  out  4*N_DIGITS  BCD number being entered, LSD in bits [3:0].
REQ-008 operando_a  out  4*N_DIGITS  latched first operand.
REQ-009 operando_b  out  4*N_DIGITS  latched second operand.
REQ-010 operador  out  2  tecla_cod minus 4'hA of latched operator.
REQ-011 contador  out  clog2(N_DIGITS+1)  digits currently in display.
REQ-012 listo  out  1  one-cycle pulse: expression complete.
REQ-013 desborde  out  1  one-cycle pulse: digit rejected, display full.

Function
REQ-014 Key event SHALL be tecla_valida=1 with registered previous value 0; action commits on that same rising edge; held key produces exactly one event.
REQ-015 FSM states: ESPERAR_A, INGRESO_A, ESPERAR_B, INGRESO_B, LISTO.
REQ-016 Digit event, contador<N_DIGITS, state ESPERAR_A/INGRESO_A/ESPERAR_B/INGRESO_B: display <= {display shifted left 4, digit}, contador+1; ESPERAR_x -> INGRESO_x.
REQ-017 Digit event, contador=N_DIGITS: display unchanged, desborde=1 for one cycle.
REQ-018 Operator event in INGRESO_A: operando_a<=display, operador latched, display<=0, contador<=0, -> ESPERAR_B.
REQ-019 Operator event in ESPERAR_B: operador replaced, nothing else changes.
REQ-020 Operator event in ESPERAR_A, INGRESO_B or LISTO: ignored.
REQ-021 Equal event in INGRESO_B: operando_b<=display, listo=1 one cycle, -> LISTO; equal in any other state ignored.
REQ-022 Digit event in LISTO: operando_a, operando_b, operador cleared, display<=digit, contador<=1, -> INGRESO_A.
REQ-023 Clear event (F) in any state: all outputs to reset values, -> ESPERAR_A; edge-detect register still tracks input.
REQ-024 listo and desborde SHALL never assert in the same cycle.

Reset
REQ-025 reset low SHALL immediately force ESPERAR_A, all outputs 0, edge-detect registers 0, independent of clk.
REQ-026 Key held high across reset release SHALL NOT produce an event until released and pressed again.

Configuration
REQ-027 Macro BACKSPACE_EN defined: rising edge of borrar in INGRESO_A/INGRESO_B shifts display right 4 (MSD<=0), contador-1; contador reaching 0 returns to ESPERAR_x.
REQ-028 borrar edge with contador=0 or in LISTO: ignored; borrar edge coincident with key event: key event wins, borrar dropped.
REQ-029 Macro undefined: borrar and its edge register SHALL be absent from logic; port remains, no effect.

Verification
REQ-030 Keys 1,2,3 each held 3 cycles -> display=16'h0123, contador=3, one update per key.
REQ-031 Keys 4,5,6,7,8 (N_DIGITS=4) -> display=16'h4567, desborde pulse on key 8 only.
REQ-032 Keys 1,2,A,C,3,E -> operando_a=16'h0012, operador=2, operando_b=16'h0003, listo one cycle.
REQ-033 After REQ-032, key 9 -> operands cleared, display=16'h0009, state INGRESO_A.
REQ-034 BACKSPACE_EN: keys 5,6, borrar -> display=16'h0005, contador=1; undefined build -> display=16'h0056.
REQ-035 reset low mid-entry with tecla_valida held -> outputs 0 asynchronously; no event after release until key re-pressed.
